// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU opcode constants and dispatcher FSM encoding
package alu_pkg;
   localparam int DATA_W = 8;
   localparam int OPER_W = 5;
   localparam logic [OPER_W-1:0] ADD_U   = 5'b00000;
   localparam logic [OPER_W-1:0] SUB_U   = 5'b00001;
   localparam logic [OPER_W-1:0] MULH_S  = 5'b01101;
   localparam logic [OPER_W-1:0] DIVU    = 5'b01110;
   localparam logic [OPER_W-1:0] REMU    = 5'b01111;
   localparam logic [OPER_W-1:0] ST_ADDR = 5'b10000;
   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
endpackage

// File: rtl/regfile8.sv
// regfile8: 8-bit register file, one sync write port, two combinational read ports and a debug read port
// Ports: clk/rst (async active-high clear of all entries), we/wa/wd write port,
// ra1/rd1 and ra2/rd2 operand reads, dbg_addr/dbg_data debug read. Entry 0 always reads 0.
module regfile8
   import alu_pkg::*;
#(
   parameter int NREG = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [2:0]        wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [2:0]        ra1,
   output logic [DATA_W-1:0] rd1,
   input  logic [2:0]        ra2,
   output logic [DATA_W-1:0] rd2,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);
   logic [DATA_W-1:0] mem [NREG];

   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      else if (we && wa != '0)
         mem[wa] <= wd;

   assign rd1      = ra1      == '0 ? '0 : mem[ra1];
   assign rd2      = ra2      == '0 ? '0 : mem[ra2];
   assign dbg_data = dbg_addr == '0 ? '0 : mem[dbg_addr];
endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: three-cycle sequencer feeding the combinational ALU from a register file
// Ports: in_* request (valid/ready, oper, rd/rs1/rs2, optional immediate for B),
// alu_a/alu_b/alu_oper to the ALU and alu_r/alu_flag back, wb_* one-cycle writeback pulse,
// flag_q flags of the last completed op, busy when not idle, dbg_addr/dbg_data register peek.
module alu_dispatch
   import alu_pkg::*;
#(
   parameter int NREG = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPER_W-1:0] in_oper,
   input  logic [2:0]        in_rd,
   input  logic [2:0]        in_rs1,
   input  logic [2:0]        in_rs2,
   input  logic              in_use_imm,
   input  logic [DATA_W-1:0] in_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OPER_W-1:0] alu_oper,
   input  logic [DATA_W-1:0] alu_r,
   input  logic [DATA_W-1:0] alu_flag,
   output logic              wb_valid,
   output logic [2:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] flag_q,
   output logic              busy,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);
   state_t            state, state_nx;
   logic [OPER_W-1:0] oper_q;
   logic [2:0]        rd_q;
   logic [DATA_W-1:0] a_q, b_q, res_q, flg_q, rs1_data, rs2_data;

   regfile8 #(.NREG(NREG)) u_rf (
      .clk      (clk),
      .rst      (rst),
      .we       (wb_valid),
      .wa       (rd_q),
      .wd       (res_q),
      .ra1      (in_rs1),
      .rd1      (rs1_data),
      .ra2      (in_rs2),
      .rd2      (rs2_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state  <= IDLE;
         oper_q <= '0;
         rd_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         res_q  <= '0;
         flg_q  <= '0;
         flag_q <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && in_valid) begin
            oper_q <= in_oper;
            rd_q   <= in_rd;
            a_q    <= rs1_data;
            b_q    <= in_use_imm ? in_imm : rs2_data;
         end
         if (state == EXEC) begin
            res_q <= alu_r;
            flg_q <= alu_flag;
         end
         if (state == WB) flag_q <= flg_q;
      end

   // The register write happens on the WB->IDLE edge, so the next accept already sees it.
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      busy     = 1'b1;
      alu_a    = '0;
      alu_b    = '0;
      alu_oper = '0;
      wb_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            state_nx = in_valid ? EXEC : IDLE;
         end
         EXEC: begin
            alu_a    = a_q;
            alu_b    = b_q;
            alu_oper = oper_q;
            state_nx = WB;
         end
         WB: begin
            wb_valid = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign wb_rd   = rd_q;
   assign wb_data = res_q;
endmodule
